// File: rtl/fp_add_arbiter_if.sv
// Requester and shared-adder bus of the floating-point add arbiter.
// The slave modport is the arbiter's view of the bus. The master modport is the surrounding datapath's view.
interface fp_add_arbiter_if #(
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int NREQ = 4
);
  localparam int W = EXP + MAN + 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   res_valid;
  logic [W-1:0]      res_data;
  logic              res_err;
  logic              add_strt;
  logic [W-1:0]      add_in1;
  logic [W-1:0]      add_in2;
  logic              add_busy;
  logic              add_valid;
  logic [W-1:0]      add_out;

  modport slave (
    input  req, a_in, b_in, add_busy, add_valid, add_out,
    output gnt, res_valid, res_data, res_err, add_strt, add_in1, add_in2
  );

  modport master (
    output req, a_in, b_in, add_busy, add_valid, add_out,
    input  gnt, res_valid, res_data, res_err, add_strt, add_in1, add_in2
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer that shares one single-precision adder among NREQ requesters.
// It routes each sum back to the requester that owns it. A watchdog aborts operations whose result never returns.
module fp_add_arbiter #(
  parameter int EXP     = 8,
  parameter int MAN     = 23,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_arbiter_if.slave   bus
);
  localparam int W  = EXP + MAN + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic [W-1:0]    in1_q, in1_d;
  logic [W-1:0]    in2_q, in2_d;

  logic            found;
  logic [PW-1:0]   winner;
  logic [PW:0]     cand;
  logic [PW-1:0]   owner_next;
  logic [NREQ-1:0] winner_oh;
  logic [NREQ-1:0] owner_oh;

  // Search for the first pending request, starting at the round-robin pointer and wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!found && bus.req[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  assign owner_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
  assign winner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    res_valid_d = '0;
    res_err_d   = 1'b0;
    res_data_d  = res_data_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    case (state_q)
      IDLE: begin
        if (found && !bus.add_busy) begin
          in1_d   = bus.a_in[int'(winner)*W +: W];
          in2_d   = bus.b_in[int'(winner)*W +: W];
          owner_d = winner;
          gnt_d   = winner_oh;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the watchdog's last cycle still counts as a normal completion.
        if (bus.add_valid) begin
          res_data_d  = bus.add_out;
          res_valid_d = owner_oh;
          ptr_d       = owner_next;
          state_d     = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          res_data_d  = '0;
          res_valid_d = owner_oh;
          res_err_d   = 1'b1;
          ptr_d       = owner_next;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.add_strt  = (state_q == ISSUE);
  assign bus.add_in1   = in1_q;
  assign bus.add_in2   = in2_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter with a behavioural 4-cycle adder model.
// It runs directed scenarios plus a randomized round-robin run that is checked against a rule-level model.
module tb_fp_add_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy_force;
  logic dead;
  int   checks = 0;
  int   passed = 0;

  fp_add_arbiter_if #(.EXP(8), .MAN(23), .NREQ(NREQ)) bus ();

  fp_add_arbiter #(.EXP(8), .MAN(23), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-precision <-> real conversion, exact for the small values used here.
  function automatic real sp2real(logic [31:0] s);
    if (s[30:23] == 8'd0) return 0.0;
    return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] real2sp(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] int2sp(int v);
    return real2sp(real'(v));
  endfunction

  function automatic int rr_pick(int p, logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Stand-in for the shared adder: the result appears four cycles after the start pulse and is cleared by reset.
  logic [3:0]  vpipe;
  logic [31:0] dpipe [4];
  always @(posedge clk) begin
    if (!rst) begin
      vpipe <= '0;
      for (int i = 0; i < 4; i++) dpipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[2:0], bus.add_strt & ~dead};
      dpipe[0] <= real2sp(sp2real(bus.add_in1) + sp2real(bus.add_in2));
      for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign bus.add_valid = vpipe[3];
  assign bus.add_out   = dpipe[3];
  assign bus.add_busy  = busy_force;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    bus.req    = '0;
    busy_force = 1'b0;
    dead       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_ops(int i, logic [31:0] a, logic [31:0] b);
    bus.a_in[i*32 +: 32] = a;
    bus.b_in[i*32 +: 32] = b;
  endtask

  task automatic wait_gnt(output int idx, output int lat);
    idx = -1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.gnt != '0) begin
        lat = k;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) idx = i;
        if (!$onehot(bus.gnt)) idx = -2;
        if (idx >= 0) bus.req[idx] = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_res(output int idx, output logic [31:0] data, output logic err, output int lat);
    idx  = -1;
    lat  = 0;
    data = '0;
    err  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.res_valid != '0) begin
        lat  = k;
        data = bus.res_data;
        err  = bus.res_err;
        for (int i = 0; i < NREQ; i++) if (bus.res_valid[i]) idx = i;
        if (!$onehot(bus.res_valid)) idx = -2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.a_in = '1;
    bus.b_in = '1;
    do_reset();
    checks++; if (bus.gnt !== 4'd0) $display("[TB] FAIL reset_gnt: got %h expected 0", bus.gnt); else passed++;
    checks++; if (bus.res_valid !== 4'd0) $display("[TB] FAIL reset_res_valid: got %h expected 0", bus.res_valid); else passed++;
    checks++; if (bus.res_err !== 1'b0) $display("[TB] FAIL reset_res_err: got %b expected 0", bus.res_err); else passed++;
    checks++; if (bus.res_data !== 32'd0) $display("[TB] FAIL reset_res_data: got %h expected 0", bus.res_data); else passed++;
    checks++; if (bus.add_strt !== 1'b0) $display("[TB] FAIL reset_add_strt: got %b expected 0", bus.add_strt); else passed++;
    checks++; if ({bus.add_in1, bus.add_in2} !== 64'd0) $display("[TB] FAIL reset_add_in: got %h expected 0", {bus.add_in1, bus.add_in2}); else passed++;
  endtask

  task automatic test_single();
    int idx, lat;
    logic [31:0] d;
    logic e;
    do_reset();
    set_ops(0, 32'h3F800000, 32'h40000000);
    bus.req = 4'b0001;
    wait_gnt(idx, lat);
    checks++; if (idx !== 0 || lat !== 1) $display("[TB] FAIL single_gnt: got idx %0d lat %0d expected idx 0 lat 1", idx, lat); else passed++;
    checks++; if (bus.add_strt !== 1'b1) $display("[TB] FAIL single_strt: got %b expected 1", bus.add_strt); else passed++;
    checks++; if (bus.add_in1 !== 32'h3F800000 || bus.add_in2 !== 32'h40000000)
      $display("[TB] FAIL single_add_in: got %h %h expected 3f800000 40000000", bus.add_in1, bus.add_in2); else passed++;
    wait_res(idx, d, e, lat);
    checks++; if (idx !== 0 || lat !== 5) $display("[TB] FAIL single_res_route: got idx %0d lat %0d expected idx 0 lat 5", idx, lat); else passed++;
    checks++; if (d !== 32'h40400000 || e !== 1'b0) $display("[TB] FAIL single_res_data: got %h err %b expected 40400000 err 0", d, e); else passed++;
    tick();
    checks++; if (bus.res_valid !== 4'd0 || bus.res_data !== 32'h40400000)
      $display("[TB] FAIL single_hold: got valid %h data %h expected 0 40400000", bus.res_valid, bus.res_data); else passed++;
  endtask

  task automatic test_all_four();
    logic [31:0] ea [4] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000};
    logic [31:0] eb [4] = '{32'h40000000, 32'h40800000, 32'hC0200000, 32'h3F000000};
    logic [31:0] es [4] = '{32'h40400000, 32'h40E00000, 32'h40200000, 32'h41280000};
    int idx, lat, ridx;
    logic [31:0] d;
    logic e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, ea[i], eb[i]);
    bus.req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      wait_gnt(idx, lat);
      checks++; if (idx !== k) $display("[TB] FAIL all4_gnt_order: got %0d expected %0d", idx, k); else passed++;
      wait_res(ridx, d, e, lat);
      checks++; if (ridx !== k || d !== es[k] || e !== 1'b0)
        $display("[TB] FAIL all4_result: got idx %0d data %h err %b expected idx %0d data %h err 0", ridx, d, e, k, es[k]); else passed++;
    end
  endtask

  task automatic test_rr_pointer();
    int idx, lat, ridx;
    logic [31:0] d;
    logic e;
    do_reset();
    set_ops(2, int2sp(6), int2sp(7));
    bus.req = 4'b0100;
    wait_gnt(idx, lat);
    wait_res(ridx, d, e, lat);
    checks++; if (ridx !== 2 || d !== int2sp(13)) $display("[TB] FAIL rr_first: got idx %0d data %h expected idx 2 data %h", ridx, d, int2sp(13)); else passed++;
    set_ops(0, int2sp(1), int2sp(1));
    set_ops(3, int2sp(3), int2sp(3));
    bus.req = 4'b1001;
    wait_gnt(idx, lat);
    checks++; if (idx !== 3) $display("[TB] FAIL rr_order_first: got %0d expected 3", idx); else passed++;
    wait_res(ridx, d, e, lat);
    wait_gnt(idx, lat);
    checks++; if (idx !== 0) $display("[TB] FAIL rr_order_second: got %0d expected 0", idx); else passed++;
    wait_res(ridx, d, e, lat);
    checks++; if (ridx !== 0 || d !== int2sp(2)) $display("[TB] FAIL rr_second_res: got idx %0d data %h expected idx 0 data %h", ridx, d, int2sp(2)); else passed++;
  endtask

  task automatic test_timeout();
    int idx, lat, ridx;
    logic [31:0] d;
    logic e;
    do_reset();
    dead = 1'b1;
    set_ops(1, int2sp(9), int2sp(4));
    bus.req = 4'b0010;
    wait_gnt(idx, lat);
    wait_res(ridx, d, e, lat);
    checks++; if (lat !== TIMEOUT + 2) $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 2); else passed++;
    checks++; if (ridx !== 1 || e !== 1'b1 || d !== 32'd0)
      $display("[TB] FAIL timeout_result: got idx %0d err %b data %h expected idx 1 err 1 data 0", ridx, e, d); else passed++;
    dead = 1'b0;
    set_ops(2, int2sp(-8), int2sp(3));
    set_ops(0, int2sp(5), int2sp(5));
    bus.req = 4'b0101;
    wait_gnt(idx, lat);
    checks++; if (idx !== 2) $display("[TB] FAIL timeout_next_gnt: got %0d expected 2", idx); else passed++;
    wait_res(ridx, d, e, lat);
    checks++; if (ridx !== 2 || d !== int2sp(-5) || e !== 1'b0)
      $display("[TB] FAIL timeout_next_res: got idx %0d data %h err %b expected idx 2 data %h err 0", ridx, d, e, int2sp(-5)); else passed++;
    wait_gnt(idx, lat);
    wait_res(ridx, d, e, lat);
  endtask

  task automatic test_busy();
    int idx, lat, ridx;
    logic [31:0] d;
    logic e;
    logic seen;
    do_reset();
    busy_force = 1'b1;
    set_ops(0, int2sp(20), int2sp(22));
    bus.req = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.gnt != '0 || bus.add_strt) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL busy_block: got grant-or-strt %b expected 0", seen); else passed++;
    busy_force = 1'b0;
    wait_gnt(idx, lat);
    checks++; if (idx !== 0 || lat !== 1) $display("[TB] FAIL busy_release: got idx %0d lat %0d expected idx 0 lat 1", idx, lat); else passed++;
    wait_res(ridx, d, e, lat);
    checks++; if (ridx !== 0 || d !== int2sp(42)) $display("[TB] FAIL busy_res: got idx %0d data %h expected idx 0 data %h", ridx, d, int2sp(42)); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int idx, lat, ridx;
    logic [31:0] d;
    logic e;
    do_reset();
    set_ops(2, int2sp(11), int2sp(12));
    bus.req = 4'b0100;
    wait_gnt(idx, lat);
    tick();
    tick();
    rst = 1'b0;
    set_ops(1, int2sp(30), int2sp(-40));
    set_ops(3, int2sp(2), int2sp(2));
    bus.req = 4'b1010;
    tick();
    checks++; if ({bus.gnt, bus.res_valid, bus.res_err, bus.add_strt} !== 10'd0 || {bus.res_data, bus.add_in1, bus.add_in2} !== 96'd0)
      $display("[TB] FAIL midreset_outputs: got gnt %h rv %h err %b strt %b data %h in1 %h in2 %h expected all 0",
               bus.gnt, bus.res_valid, bus.res_err, bus.add_strt, bus.res_data, bus.add_in1, bus.add_in2); else passed++;
    rst = 1'b1;
    wait_gnt(idx, lat);
    checks++; if (idx !== 1 || lat !== 1) $display("[TB] FAIL midreset_gnt: got idx %0d lat %0d expected idx 1 lat 1", idx, lat); else passed++;
    wait_res(ridx, d, e, lat);
    checks++; if (ridx !== 1 || d !== int2sp(-10) || lat !== 5)
      $display("[TB] FAIL midreset_res: got idx %0d data %h lat %0d expected idx 1 data %h lat 5", ridx, d, lat, int2sp(-10)); else passed++;
    wait_gnt(idx, lat);
    wait_res(ridx, d, e, lat);
  endtask

  task automatic test_random();
    int idx, lat, ridx, p, exp_idx;
    logic [31:0] d;
    logic e;
    logic [NREQ-1:0] pending;
    int op_a [NREQ];
    int op_b [NREQ];
    do_reset();
    p       = 0;
    pending = '0;
    for (int round = 0; round < 24; round++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1 || pending == '0)) begin
          op_a[i] = int'($urandom_range(0, 2000)) - 1000;
          op_b[i] = int'($urandom_range(0, 2000)) - 1000;
          set_ops(i, int2sp(op_a[i]), int2sp(op_b[i]));
          pending[i] = 1'b1;
        end
      end
      bus.req = pending;
      exp_idx = rr_pick(p, pending);
      wait_gnt(idx, lat);
      checks++; if (idx !== exp_idx || lat !== 1) $display("[TB] FAIL rand_gnt: got idx %0d lat %0d expected idx %0d lat 1", idx, lat, exp_idx); else passed++;
      if (exp_idx >= 0) pending[exp_idx] = 1'b0;
      wait_res(ridx, d, e, lat);
      checks++; if (exp_idx < 0 || ridx !== exp_idx || d !== int2sp(op_a[exp_idx] + op_b[exp_idx]) || e !== 1'b0 || lat !== 5)
        $display("[TB] FAIL rand_res: got idx %0d data %h err %b lat %0d expected idx %0d err 0 lat 5", ridx, d, e, lat, exp_idx); else passed++;
      p = (exp_idx + 1) % NREQ;
    end
    bus.req = '0;
  endtask

  initial begin
    rst        = 1'b0;
    busy_force = 1'b0;
    dead       = 1'b0;
    bus.req    = '0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    test_reset();
    test_single();
    test_all_four();
    test_rr_pointer();
    test_timeout();
    test_busy();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
